apb_lite_master19: RTL

- APB (AMBA Rev 2) initiator that turns single commands from a local request port into APB transfers.
- Drives the psel/penable/pwrite/paddr/pwdata bus that the gpio19 peripheral responds on, and returns captured prdata to the requester.
- Used by bus bridges, DFT/boot sequencers and the testbench-replacement CPU stub to program GPIO-class peripherals.
- One transfer in flight at a time; the response is held until the requester consumes it.

---
 rtl/apb_lite_master19.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/apb_lite_master19.sv
// apb_lite_master19: single-outstanding APB (AMBA Rev 2) initiator.
//
// A command taken on the cmd_* port becomes one APB transfer, which goes through
// SETUP and then ACCESS. The result is held on the rsp_* port until the
// requester consumes it. Every APB output comes from a register, so no APB
// input reaches an output without passing through a flop.
//
// Optional feature (compile-time macro APB_LITE_MASTER_PREADY_EN):
//   defined   - ACCESS waits on pready19. A wait counter ends the transfer with
//               rsp_err19 = 1 after TIMEOUT ACCESS cycles that have no ready.
//   undefined - pready19 is ignored, ACCESS lasts one cycle, rsp_err19 = 0.
//
// Ports:
//   pclk19, p_reset19        clock; asynchronous active-high reset
//   cmd_valid19/ready19      command handshake (ready only in IDLE)
//   cmd_write19/addr19/wdata19  command payload, sampled on accept
//   rsp_valid19/ready19      response handshake
//   rsp_rdata19, rsp_err19   read data (0 for writes), timeout flag
//   psel19 .. pwdata19       APB request outputs
//   prdata19, pready19       APB completer inputs

module apb_lite_master19 #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk19,
  input  logic              p_reset19,
  // Command port
  input  logic              cmd_valid19,
  output logic              cmd_ready19,
  input  logic              cmd_write19,
  input  logic [ADDR_W-1:0] cmd_addr19,
  input  logic [DATA_W-1:0] cmd_wdata19,
  // Response port
  output logic              rsp_valid19,
  input  logic              rsp_ready19,
  output logic [DATA_W-1:0] rsp_rdata19,
  output logic              rsp_err19,
  // APB
  output logic              psel19,
  output logic              penable19,
  output logic              pwrite19,
  output logic [ADDR_W-1:0] paddr19,
  output logic [DATA_W-1:0] pwdata19,
  input  logic [DATA_W-1:0] prdata19,
  input  logic              pready19
);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } state_e;

  state_e              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  // Set one cycle after reset is released. It keeps cmd_ready19 low while reset
  // is applied and during the first cycle after release.
  logic                run_q;
  logic                done;
  logic                err;

`ifdef APB_LITE_MASTER_PREADY_EN
  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rsp_err_q, rsp_err_d;
`else
  // Unused inputs/parameters in the single-cycle ACCESS build.
  logic        unused_pready;
  logic [31:0] unused_timeout;
  assign unused_pready  = pready19;
  assign unused_timeout = TIMEOUT;
`endif

  assign cmd_ready19 = (state_q == StIdle) && run_q;

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    done        = 1'b0;
    err         = 1'b0;
`ifdef APB_LITE_MASTER_PREADY_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (cmd_valid19 && cmd_ready19) begin
          pwrite_d  = cmd_write19;
          paddr_d   = cmd_addr19;
          pwdata_d  = cmd_write19 ? cmd_wdata19 : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = StSetup;
        end
      end

      StSetup: begin
        penable_d = 1'b1;
        state_d   = StAccess;
`ifdef APB_LITE_MASTER_PREADY_EN
        cnt_d     = '0;
`endif
      end

      StAccess: begin
`ifdef APB_LITE_MASTER_PREADY_EN
        // A ready in the last allowed cycle takes priority over the timeout.
        if (pready19) begin
          done = 1'b1;
        end else if (cnt_q == CntLast) begin
          done = 1'b1;
          err  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        done = 1'b1;
`endif
        if (done) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (pwrite_q || err) ? '0 : prdata19;
`ifdef APB_LITE_MASTER_PREADY_EN
          rsp_err_d   = err;
`endif
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwrite_d    = 1'b0;
          state_d     = StResp;
        end
      end

      StResp: begin
        if (rsp_ready19) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk19 or posedge p_reset19) begin
    if (p_reset19) begin
      state_q     <= StIdle;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      run_q       <= 1'b1;
    end
  end

`ifdef APB_LITE_MASTER_PREADY_EN
  always_ff @(posedge pclk19 or posedge p_reset19) begin
    if (p_reset19) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err19 = rsp_err_q;
`else
  assign rsp_err19 = 1'b0;
`endif

  assign psel19      = psel_q;
  assign penable19   = penable_q;
  assign pwrite19    = pwrite_q;
  assign paddr19     = paddr_q;
  assign pwdata19    = pwdata_q;
  assign rsp_valid19 = rsp_valid_q;
  assign rsp_rdata19 = rsp_rdata_q;

endmodule
